// File: rtl/fp32_div_defs.sv
// Shared constants and the stage-1 record for the fp32 divider back end.
package fp32_div_defs;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = 24;

    // Exponent width carried between stages: the 10-bit signed input plus
    // one bit of headroom for the -1 normalisation and the +1 rounding carry.
    localparam int EXP_W   = 11;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Normalised operand handed from stage 1 to stage 2
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;   // two's complement, biased
        logic [MANT_W-1:0] mant;  // hidden bit at [MANT_W-1]
        logic              g;
        logic              r;
        logic              s;
        logic              nan;
        logic              inf;
        logic              zero;
    } s1_rec_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even of a 24-bit mantissa with guard/round/sticky bits.
module fp_rne_round
    import fp32_div_defs::*;
(
    input  logic [MANT_W-1:0] mant,
    input  logic              g,
    input  logic              r,
    input  logic              s,
    output logic [MANT_W-1:0] mant_rnd,
    output logic              carry,
    output logic              inexact
);

    logic          inc_s;
    logic [MANT_W:0] sum_s;

    // Increment on above-half, or exactly half with an odd lsb; renormalise on carry-out
    always_comb begin
        inc_s    = g & (r | s | mant[0]);
        sum_s    = {1'b0, mant} + {{MANT_W{1'b0}}, inc_s};
        carry    = sum_s[MANT_W];
        inexact  = g | r | s;
        if (sum_s[MANT_W]) begin
            mant_rnd = {1'b1, {(MANT_W-1){1'b0}}};
        end else begin
            mant_rnd = sum_s[MANT_W-1:0];
        end
    end

endmodule

// File: rtl/fp32_div_round_pack.sv
// Divider back end: normalise the mantissa quotient, round to nearest-even,
// resolve overflow/underflow and special operands, pack binary32.
// Two registered stages with a valid/ready handshake on each side.
module fp32_div_round_pack
    import fp32_div_defs::*;
#(
    parameter int QW = 27,   // only 27 is supported
    parameter int EW = 10    // only 10 is supported (EXP_W = EW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] in_q,
    input  logic          in_rem_nz,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic          in_nan,
    input  logic          in_inf,
    input  logic          in_zero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic          out_overflow,
    output logic          out_underflow,
    output logic          out_inexact
);

    localparam logic [EXP_W-1:0] EXP_OVF_C = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_UNF_C = {EXP_W{1'b0}};

    // Pipeline state
    logic       v1_r;
    s1_rec_t    s1_r;
    logic       v2_r;

    // Handshake
    logic       ready1_s;
    logic       ready2_s;

    // Stage 1 next value
    s1_rec_t          s1_next_s;
    logic [EXP_W-1:0] exp_ext_s;

    // Stage 2 datapath
    logic [MANT_W-1:0] mant_rnd_s;
    logic              carry_s;
    logic              inx_rnd_s;
    logic [EXP_W-1:0]  exp_rnd_s;
    logic [31:0]       res_next_s;
    logic              ovf_next_s;
    logic              unf_next_s;
    logic              inx_next_s;
    logic              unused_bits_s;

    // Backward ready chain: a stage can load when empty or when its content moves on
    always_comb begin
        ready2_s = ~v2_r | out_ready;
        ready1_s = ~v1_r | ready2_s;
        in_ready = ready1_s;
    end

    // Stage 1: pick the 24 significant bits depending on whether the quotient is >= 1
    always_comb begin
        s1_next_s      = '0;
        exp_ext_s      = {{(EXP_W-EW){in_exp[EW-1]}}, in_exp};
        s1_next_s.sign = in_sign;
        s1_next_s.nan  = in_nan;
        s1_next_s.inf  = in_inf;
        s1_next_s.zero = in_zero;
        if (in_q[QW-1]) begin
            s1_next_s.mant = in_q[QW-1:3];
            s1_next_s.g    = in_q[2];
            s1_next_s.r    = in_q[1];
            s1_next_s.s    = in_q[0] | in_rem_nz;
            s1_next_s.exp  = exp_ext_s;
        end else begin
            s1_next_s.mant = in_q[QW-2:2];
            s1_next_s.g    = in_q[1];
            s1_next_s.r    = in_q[0];
            s1_next_s.s    = in_rem_nz;
            s1_next_s.exp  = exp_ext_s - {{(EXP_W-1){1'b0}}, 1'b1};
        end
    end

    fp_rne_round u_round (
        .mant     (s1_r.mant),
        .g        (s1_r.g),
        .r        (s1_r.r),
        .s        (s1_r.s),
        .mant_rnd (mant_rnd_s),
        .carry    (carry_s),
        .inexact  (inx_rnd_s)
    );

    // Stage 2: specials first, then exponent range, then the normal pack
    always_comb begin
        exp_rnd_s     = s1_r.exp + {{(EXP_W-1){1'b0}}, carry_s};
        res_next_s    = 32'h0000_0000;
        ovf_next_s    = 1'b0;
        unf_next_s    = 1'b0;
        inx_next_s    = 1'b0;
        unused_bits_s = ^{mant_rnd_s[MANT_W-1], exp_rnd_s[EXP_W-1:8]};
        if (s1_r.nan) begin
            res_next_s = QNAN;
        end else if (s1_r.inf) begin
            res_next_s = {s1_r.sign, 8'hFF, 23'd0};
        end else if (s1_r.zero) begin
            res_next_s = {s1_r.sign, 31'd0};
        end else if ($signed(exp_rnd_s) >= $signed(EXP_OVF_C)) begin
            res_next_s = {s1_r.sign, 8'hFF, 23'd0};
            ovf_next_s = 1'b1;
            inx_next_s = 1'b1;
        end else if ($signed(exp_rnd_s) <= $signed(EXP_UNF_C)) begin
            // No subnormal output: anything below the normal range flushes to zero
            res_next_s = {s1_r.sign, 31'd0};
            unf_next_s = 1'b1;
            inx_next_s = 1'b1;
        end else begin
            res_next_s = {s1_r.sign, exp_rnd_s[7:0], mant_rnd_s[FRAC_W-1:0]};
            inx_next_s = inx_rnd_s;
        end
    end

    // Stage 1 register: load a new operand whenever the stage is free to move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r <= 1'b0;
            s1_r <= '0;
        end else if (ready1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_r <= s1_next_s;
            end
        end
    end

    // Stage 2 / output register: hold steady under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_r          <= 1'b0;
            out_result    <= 32'h0000_0000;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (ready2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                out_result    <= res_next_s;
                out_overflow  <= ovf_next_s;
                out_underflow <= unf_next_s;
                out_inexact   <= inx_next_s;
            end
        end
    end

    assign out_valid = v2_r;

endmodule

// File: tb/tb_fp32_div_round_pack.sv
// Scoreboard bench for fp32_div_round_pack: the driver pushes the expected
// response on each accept; a negedge monitor pops and compares on each output transfer.
module tb_fp32_div_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_q;
    logic        in_rem_nz;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic        in_nan;
    logic        in_inf;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    fp32_div_round_pack #(.QW(27), .EW(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_q          (in_q),
        .in_rem_nz     (in_rem_nz),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_nan        (in_nan),
        .in_inf        (in_inf),
        .in_zero       (in_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          acc;
        bit          chk_lat;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_sent    = 0;
    int   n_recv    = 0;
    int   n_dropped = 0;
    int   cyc       = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every output transfer against the head of the scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            n_recv   = n_recv + 1;
            n_checks = n_checks + 1;
            if (sb.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_output actual=%h required=none", out_result);
            end else begin
                e = sb.pop_front();
                if ({out_result, out_overflow, out_underflow, out_inexact} !==
                    {e.res, e.ovf, e.unf, e.inx}) begin
                    n_fail = n_fail + 1;
                    $display("FAIL vec%0d result/ovf/unf/inx actual=%h/%b/%b/%b required=%h/%b/%b/%b",
                             e.id, out_result, out_overflow, out_underflow, out_inexact,
                             e.res, e.ovf, e.unf, e.inx);
                end
                if (e.chk_lat) begin
                    n_checks = n_checks + 1;
                    if ((cyc + 1 - e.acc) != 2) begin
                        n_fail = n_fail + 1;
                        $display("FAIL vec%0d latency actual=%0d required=2", e.id, cyc + 1 - e.acc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one operand until accepted (bounded), then record its expected result
    task automatic send(input int id, input logic [26:0] q, input logic rem, input logic sign,
                        input logic [9:0] e, input logic nan, input logic inf, input logic zero,
                        input logic [31:0] res, input logic ovf, input logic unf, input logic inx,
                        input bit lat);
        exp_t ent;
        bit   accepted = 1'b0;
        int   acc_c    = 0;
        in_q      = q;
        in_rem_nz = rem;
        in_sign   = sign;
        in_exp    = e;
        in_nan    = nan;
        in_inf    = inf;
        in_zero   = zero;
        in_valid  = 1'b1;
        for (int t = 0; t < 40 && !accepted; t++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                acc_c    = cyc + 1;
            end
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (accepted) begin
            ent.res = res; ent.ovf = ovf; ent.unf = unf; ent.inx = inx;
            ent.acc = acc_c; ent.chk_lat = lat; ent.id = id;
            sb.push_back(ent);
            n_sent = n_sent + 1;
        end else begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL vec%0d accept_timeout actual=0 required=1", id);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_q = '0; in_rem_nz = 1'b0; in_sign = 1'b0;
        in_exp = '0; in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_flags", {out_overflow, out_underflow, out_inexact}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("in_ready_after_rst", in_ready, 1);

        // Normal, rounding, range and special vectors at full throughput
        send( 1, 27'h4000000, 0, 0, 10'd127, 0, 0, 0, 32'h3F800000, 0, 0, 0, 1);
        send( 2, 27'h2000000, 0, 0, 10'd127, 0, 0, 0, 32'h3F000000, 0, 0, 0, 1);
        send( 3, 27'h2000000, 0, 1, 10'd127, 0, 0, 0, 32'hBF000000, 0, 0, 0, 1);
        send( 4, 27'h4000004, 0, 0, 10'd127, 0, 0, 0, 32'h3F800000, 0, 0, 1, 1);
        send( 5, 27'h400000C, 0, 0, 10'd127, 0, 0, 0, 32'h3F800002, 0, 0, 1, 1);
        send( 6, 27'h4000004, 1, 0, 10'd127, 0, 0, 0, 32'h3F800001, 0, 0, 1, 1);
        send( 7, 27'h7FFFFFC, 0, 0, 10'd127, 0, 0, 0, 32'h40000000, 0, 0, 1, 1);
        send( 8, 27'h4000000, 0, 0, 10'd255, 0, 0, 0, 32'h7F800000, 1, 0, 1, 1);
        send( 9, 27'h4000000, 0, 0, 10'd0,   0, 0, 0, 32'h00000000, 0, 1, 1, 1);
        send(10, 27'h4000000, 0, 0, 10'd254, 0, 0, 0, 32'h7F000000, 0, 0, 0, 1);
        send(11, 27'h7FFFFFC, 0, 0, 10'd254, 0, 0, 0, 32'h7F800000, 1, 0, 1, 1);
        send(12, 27'h2000000, 0, 1, 10'd1,   0, 0, 0, 32'h80000000, 0, 1, 1, 1);
        send(13, 27'h4000000, 0, 0, 10'd1,   0, 0, 0, 32'h00800000, 0, 0, 0, 1);
        send(14, 27'h4000000, 0, 1, 10'h3FB, 0, 0, 0, 32'h80000000, 0, 1, 1, 1);
        send(15, 27'h2000003, 0, 0, 10'd127, 0, 0, 0, 32'h3F000001, 0, 0, 1, 1);
        send(16, 27'h4000004, 1, 1, 10'd200, 1, 1, 0, 32'h7FC00000, 0, 0, 0, 1);
        send(17, 27'h7FFFFFC, 1, 1, 10'd255, 0, 1, 0, 32'hFF800000, 0, 0, 0, 1);
        send(18, 27'h4000000, 0, 0, 10'd127, 0, 0, 1, 32'h00000000, 0, 0, 0, 1);
        send(19, 27'h400000C, 1, 1, 10'd0,   0, 0, 1, 32'h80000000, 0, 0, 0, 1);
        drain();

        // Backpressure: two fill the pipe, the third waits until out_ready returns
        out_ready = 1'b0;
        send(20, 27'h4000000, 0, 0, 10'd127, 0, 0, 0, 32'h3F800000, 0, 0, 0, 0);
        send(21, 27'h400000C, 0, 0, 10'd128, 0, 0, 0, 32'h40000002, 0, 0, 1, 0);
        check("in_ready_full", in_ready, 0);
        check("out_valid_held", out_valid, 1);
        check("out_result_held", out_result, 32'h3F800000);
        fork
            send(22, 27'h4000000, 0, 1, 10'd130, 0, 0, 0, 32'hC1000000, 0, 0, 0, 0);
            begin
                repeat (3) @(posedge clk);
                #2;
                check("in_ready_stalled", in_ready, 0);
                check("out_result_stable", out_result, 32'h3F800000);
                out_ready = 1'b1;
            end
        join
        drain();
        check("recv_eq_sent_bp", n_recv, n_sent);

        // Asynchronous reset with a result waiting at the output
        out_ready = 1'b0;
        send(23, 27'h4000000, 0, 0, 10'd127, 0, 0, 0, 32'h3F800000, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_result", out_result, 32'h0);
        n_dropped = n_dropped + sb.size();
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("in_ready_post_rst", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("no_ghost_output", out_valid, 0);
        send(24, 27'h2000000, 0, 1, 10'd130, 0, 0, 0, 32'hC0800000, 0, 0, 0, 1);
        drain();
        check("recv_eq_sent_total", n_recv, n_sent - n_dropped);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_div_round_pack.md
Name: fp32_div_round_pack

Overview:
- Post-divide back end of the single-precision divider.
- Consumes the 27-bit mantissa quotient from the combinational non-restoring mantissa divider, together with sign, pre-computed exponent and special-case flags from the unpack stage.
- Normalises, rounds to nearest-even, handles exponent overflow/underflow and special operands, and packs an IEEE-754 binary32 result.
- Two-stage registered pipeline with valid/ready handshake on both sides.

Parameters:
- QW, 27, quotient width; only 27 supported.
- EW, 10, width of signed biased exponent input (two's complement).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream operand valid
- in_ready  output  1  stage can accept
- in_q  input  27  quotient; bit26 weight 2^0, value in [0.5,2)
- in_rem_nz  input  1  divider remainder non-zero (sticky source)
- in_sign  input  1  result sign (sa ^ sb)
- in_exp  input  EW  biased exponent ea-eb+127, signed
- in_nan  input  1  result is NaN
- in_inf  input  1  result is infinity (x/0, inf/finite)
- in_zero  input  1  result is zero (0/x, finite/inf)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_result  output  32  packed binary32
- out_overflow  output  1  rounded exponent ≥ 255
- out_underflow  output  1  rounded exponent ≤ 0 (flushed)
- out_inexact  output  1  any of guard/round/sticky set, or overflow/underflow

Behaviour:
- Reset (async, immediate):
  - Both stage valid bits = 0.
  - out_result = 0; all flags = 0.
  - in_ready = 1 after reset deasserts.
  - Reset mid-flight discards all in-flight data.
- Handshake:
  - Transfer when valid & ready on the same edge.
  - ready2 = !v2 | out_ready; ready1 = !v1 | ready2; in_ready = ready1 (combinational from out_ready).
  - Latency 2 cycles from accepting edge to out_valid.
  - Full throughput: 1 result/cycle when out_ready = 1.
  - Data is held stable while out_valid & !out_ready.
- Stage 1 (normalise):
  - If q[26] = 1: mant = q[26:3], g = q[2], r = q[1], s = q[0] | rem_nz, exp = in_exp.
  - Else: mant = q[25:2], g = q[1], r = q[0], s = rem_nz, exp = in_exp - 1.
  - q[26] = q[25] = 0 is illegal for non-special operands and is don't-care.
  - Exponent carried as EW+1 signed to absorb ±1.
- Stage 2 (round/pack):
  - inc = g & (r | s | mant[0]); m25 = mant + inc.
  - If m25[24]: mant = 24'h800000, exp + 1.
  - Overflow when exp ≥ 255: result = {sign, 8'hFF, 23'd0}; overflow = 1, inexact = 1.
  - Underflow when exp ≤ 0: result = {sign, 31'd0}; underflow = 1, inexact = 1. No subnormal output.
  - Otherwise: result = {sign, exp[7:0], mant[22:0]}; inexact = g | r | s.
- Special priority nan > inf > zero; specials override all arithmetic and force all flags to 0.
  - nan → 32'h7FC00000, sign ignored.
  - inf → {sign, 8'hFF, 0}.
  - zero → {sign, 31'd0}.
- Simultaneous accept and emit on the same edge is legal in both stages.

Decomposition:
- Shared package/include fp32_div_defs holds:
  - BIAS = 127, EXP_MAX = 255, QNAN = 32'h7FC00000, FRAC_W = 23, MANT_W = 24.
  - Stage-1 record: sign, exp, mant, g, r, s, special flags.
- One sub-module, fp_rne_round: combinational 24-bit mantissa + g/r/s in; rounded mantissa, carry-out and inexact out.
- Pipeline registers and handshake stay in the top.

Test Plan:
1. q = 27'h4000000, exp = 127, sign = 0, rem_nz = 0 → out_result 32'h3F800000, no flags, out_valid exactly 2 cycles after accept.
2. q = 27'h2000000, exp = 127 → 32'h3F000000; same with sign = 1 → 32'hBF000000.
3. Tie-to-even:
   - q = 27'h4000004 → 32'h3F800000, inexact = 1.
   - q = 27'h400000C → 32'h3F800002, inexact = 1.
   - q = 27'h4000004 with rem_nz = 1 → 32'h3F800001.
4. Mantissa carry: q = 27'h7FFFFFC, exp = 127 → 32'h40000000, inexact = 1. Overflow: q = 27'h4000000, exp = 255 → 32'h7F800000, overflow = 1. Underflow: exp = 0 → 32'h00000000, underflow = 1.
5. Specials:
   - in_nan with in_inf → 32'h7FC00000.
   - in_inf, sign = 1 → 32'hFF800000.
   - in_zero → 32'h00000000.
   - All flags 0 in every case.
6. Backpressure and reset:
   - 3 back-to-back inputs with out_ready = 0 → in_ready drops after the 2nd accept.
   - Releasing out_ready yields all 3 results in order, none lost or duplicated.
   - Asserting rst mid-stream clears out_valid immediately, without waiting for a clk edge.
